smi_transaction_throttle: RTL
=============================

// Module: smi_transaction_throttle
// PURPOSE
//  Sits directly downstream of the scaled X4 arbiter, between its wide SMI request/response
//  ports and the memory controller. Caps outstanding transactions at MaxOutstanding:
//  a request frame may only start when a slot is free. A slot is released when the
//  matching response frame completes. Registers the request path.
// PARAMETERS
//  FlitWidth       8   bytes per flit on both sides (arbiter downstream width); >=4
//  MaxOutstanding  16  max request frames issued without a completed response; 1..255
//  CountWidth      8   width of the outstanding counter; 2^CountWidth > MaxOutstanding
// PORTS
//  clk               in   1            clock; all state changes on rising edge
//  srst              in   1            reset, asynchronous assert, active-low
//  smiReqInReady     in   1            request flit valid, from arbiter
//  smiReqInEofc      in   8            0 = mid-frame; 1..FlitWidth = last flit, valid bytes
//  smiReqInData      in   FlitWidth*8  request flit data
//  smiReqInStop      out  1            backpressure to arbiter
//  smiReqOutReady    out  1            registered request flit valid, to memory
//  smiReqOutEofc     out  8            registered eofc
//  smiReqOutData     out  FlitWidth*8  registered data
//  smiReqOutStop     in   1            backpressure from memory
//  smiRespInReady    in   1            response flit valid, from memory
//  smiRespInEofc     in   8            response eofc
//  smiRespInData     in   FlitWidth*8  response data
//  smiRespInStop     out  1            = smiRespOutStop (combinational)
//  smiRespOutReady   out  1            = smiRespInReady (combinational), to arbiter steer
//  smiRespOutEofc    out  8            = smiRespInEofc
//  smiRespOutData    out  FlitWidth*8  = smiRespInData
//  smiRespOutStop    in   1            backpressure from arbiter
//  outstandingCount  out  CountWidth   current reserved slots
//  throttleActive    out  1            registered; 1 while a frame start is held for lack of a slot
//  protocolError     out  1            sticky; response EOF seen with outstandingCount==0
// BEHAVIOUR
//  - Transfer: a flit moves when Ready=1 and Stop=0 in the same cycle.
//  - Reset (srst=0, async): outReg empty, smiReqOutReady=0, Eofc/Data=0, count=0,
//    state=REQ_IDLE, throttleActive=0, protocolError=0. A frame in flight is discarded.
//    Downstream must be reset together with this block.
//  - Request FSM:
//    - REQ_IDLE (next flit is start of frame):
//      - Accept only if count < MaxOutstanding.
//      - On accept: reserve a slot (count+1).
//      - Go to REQ_FRAME if eofc==0; stay in REQ_IDLE if single-flit frame.
//    - REQ_FRAME: accept flits freely; a flit with eofc!=0 returns to REQ_IDLE.
//  - Output register (one entry) on the request path:
//    - smiReqInStop = ~(regEmpty | ~smiReqOutStop) | (REQ_IDLE & count==MaxOutstanding).
//    - Latency is 1 cycle. Full throughput when not stalled.
//  - Response path: zero latency, no buffering. Frame end = transfer with eofc!=0,
//    which releases one slot.
//  - Counter:
//    - count_next = count + reserve - release.
//    - Simultaneous reserve and release: unchanged.
//    - When count==MaxOutstanding and a release occurs in the same cycle: the stall
//      stays for that cycle, because the gate uses the registered count.
//  - Underflow: release with count==0 leaves count at 0 and sets protocolError.
//    Only reset clears it.
//  - throttleActive <= REQ_IDLE & smiReqInReady & count==MaxOutstanding.
// STRUCTURE
//  - Shared package smi_pkg: SMI_EOFC_W=8, SMI_EOFC_MID=8'd0, and the FSM state
//    enum {REQ_IDLE, REQ_FRAME}.
//  - One submodule, smi_flit_register: a one-entry Ready/Stop pipeline register,
//    parameterised by FlitWidth.
//  - Counter, FSM and response monitor live in the top level.
// TESTING
//  1. Reset release, idle inputs -> all outputs 0; assert srst mid-frame -> outputs
//     clear asynchronously, no flit emitted.
//  2. MaxOutstanding=2; three 3-flit request frames, no responses -> frames 1-2 pass
//     with 1-cycle latency, count=2; frame 3 first flit held, throttleActive=1.
//  3. Continue test 2: send one single-flit response (eofc=8) -> count 2->1. Frame 3
//     starts the cycle after; count returns to 2; throttleActive=0.
//  4. Same-cycle request SOF accept and response EOF with count=1 -> count stays 1.
//     smiReqOutData matches input one cycle later.
//  5. Random smiReqOutStop at 50% on 100 frames -> output flit sequence, including
//     eofc, identical to input; no drop or duplication.
//  6. Response EOF with count=0 -> count stays 0, protocolError=1 and sticky until srst=0.

Source files
------------

// File: rtl/smi_pkg.sv
// smi_pkg: shared SMI flit constants and the request-side frame FSM state type.
package smi_pkg;
    localparam int SMI_EOFC_W = 8;
    localparam logic [SMI_EOFC_W-1:0] SMI_EOFC_MID = 8'd0;
    typedef enum logic {REQ_IDLE, REQ_FRAME} reqState_t;
endpackage

// File: rtl/smi_flit_register.sv
// smi_flit_register: one-entry Ready/Stop pipeline register for SMI flits.
module smi_flit_register
    import smi_pkg::*;
#(
    parameter int FlitWidth = 8
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    inReady,
    input  logic [SMI_EOFC_W-1:0]   inEofc,
    input  logic [FlitWidth*8-1:0]  inData,
    output logic                    inStop,
    output logic                    outReady,
    output logic [SMI_EOFC_W-1:0]   outEofc,
    output logic [FlitWidth*8-1:0]  outData,
    input  logic                    outStop
);
    // Refill in the same cycle the held flit leaves, so an unstalled stream runs at full rate.
    assign inStop = outReady & outStop;

    always_ff @(posedge clk or negedge srst) begin
        if (!srst) begin
            outReady <= 1'b0;
            outEofc  <= '0;
            outData  <= '0;
        end else if (inReady && !inStop) begin
            outReady <= 1'b1;
            outEofc  <= inEofc;
            outData  <= inData;
        end else if (!outStop) begin
            outReady <= 1'b0;
        end
    end
endmodule

// File: rtl/smi_transaction_throttle.sv
// smi_transaction_throttle: caps outstanding SMI request frames, releasing a slot on each
// completed response frame; the request path is registered, the response path is a wire.
module smi_transaction_throttle
    import smi_pkg::*;
#(
    parameter int FlitWidth      = 8,
    parameter int MaxOutstanding = 16,
    parameter int CountWidth     = 8
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    smiReqInReady,
    input  logic [SMI_EOFC_W-1:0]   smiReqInEofc,
    input  logic [FlitWidth*8-1:0]  smiReqInData,
    output logic                    smiReqInStop,
    output logic                    smiReqOutReady,
    output logic [SMI_EOFC_W-1:0]   smiReqOutEofc,
    output logic [FlitWidth*8-1:0]  smiReqOutData,
    input  logic                    smiReqOutStop,
    input  logic                    smiRespInReady,
    input  logic [SMI_EOFC_W-1:0]   smiRespInEofc,
    input  logic [FlitWidth*8-1:0]  smiRespInData,
    output logic                    smiRespInStop,
    output logic                    smiRespOutReady,
    output logic [SMI_EOFC_W-1:0]   smiRespOutEofc,
    output logic [FlitWidth*8-1:0]  smiRespOutData,
    input  logic                    smiRespOutStop,
    output logic [CountWidth-1:0]   outstandingCount,
    output logic                    throttleActive,
    output logic                    protocolError
);
    localparam logic [CountWidth-1:0] MaxCount = CountWidth'(MaxOutstanding);

    reqState_t state, stateNext;
    logic      regStop, slotGate, reqAccept, slotReserve, slotRelease;

    // Gate on the registered count: a release this cycle only frees the slot next cycle.
    assign slotGate     = (state == REQ_IDLE) && (outstandingCount == MaxCount);
    assign smiReqInStop = regStop | slotGate;
    assign reqAccept    = smiReqInReady & ~smiReqInStop;
    assign slotReserve  = reqAccept && (state == REQ_IDLE);

    assign smiRespInStop   = smiRespOutStop;
    assign smiRespOutReady = smiRespInReady;
    assign smiRespOutEofc  = smiRespInEofc;
    assign smiRespOutData  = smiRespInData;
    assign slotRelease     = smiRespInReady && !smiRespOutStop && (smiRespInEofc != SMI_EOFC_MID);

    smi_flit_register #(.FlitWidth(FlitWidth)) reqReg (
        .clk      (clk),
        .srst     (srst),
        .inReady  (smiReqInReady & ~slotGate),
        .inEofc   (smiReqInEofc),
        .inData   (smiReqInData),
        .inStop   (regStop),
        .outReady (smiReqOutReady),
        .outEofc  (smiReqOutEofc),
        .outData  (smiReqOutData),
        .outStop  (smiReqOutStop)
    );

    always_ff @(posedge clk or negedge srst) begin
        if (!srst) state <= REQ_IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        if (reqAccept)
            stateNext = (smiReqInEofc == SMI_EOFC_MID) ? REQ_FRAME : REQ_IDLE;
    end

    always_ff @(posedge clk or negedge srst) begin
        if (!srst) begin
            outstandingCount <= '0;
            throttleActive   <= 1'b0;
            protocolError    <= 1'b0;
        end else begin
            if (slotReserve && !slotRelease)
                outstandingCount <= outstandingCount + CountWidth'(1);
            else if (slotRelease && !slotReserve && outstandingCount != '0)
                outstandingCount <= outstandingCount - CountWidth'(1);
            throttleActive <= slotGate & smiReqInReady;
            // Sticky: a response end with nothing outstanding means the downstream is out of step.
            if (slotRelease && outstandingCount == '0)
                protocolError <= 1'b1;
        end
    end
endmodule
